// File: rtl/clk_en_gen_pkg.sv
// Shared types and constants for the clock-enable generator.
package clk_en_gen_pkg;

    localparam int unsigned MAX_CH = 16;
    localparam int unsigned CH_W   = $clog2(MAX_CH);

    typedef enum logic [1:0] {
        SETTLE = 2'd0,
        LOCKED = 2'd1,
        APPLY  = 2'd2
    } state_e;

endpackage

// File: rtl/clk_en_chan.sv
// One phase-accumulator channel: acc += inc each cycle, the carry is the registered enable.
// With CLKEN_PHASE_EN the accumulator can be loaded instead of advanced.
module clk_en_chan #(
    parameter int unsigned ACC_W   = 32,
    parameter int unsigned DEF_INC = 0
) (
    input  logic             refclk,
    input  logic             rst_n,
    input  logic             wr_inc_i,
    input  logic [ACC_W-1:0] inc_i,
`ifdef CLKEN_PHASE_EN
    input  logic             ld_acc_i,
    input  logic [ACC_W-1:0] phase_i,
`endif
    output logic             ce_o
);

    logic [ACC_W-1:0] acc_q, acc_d;
    logic [ACC_W-1:0] inc_q;
    logic             ce_q, ce_d;
    logic [ACC_W:0]   sum_c;

    always_comb begin
        sum_c = {1'b0, acc_q} + {1'b0, inc_q};
        acc_d = sum_c[ACC_W-1:0];
        ce_d  = sum_c[ACC_W];
`ifdef CLKEN_PHASE_EN
        // A phase load replaces this cycle's add, so no carry is produced.
        if (ld_acc_i) begin
            acc_d = phase_i;
            ce_d  = 1'b0;
        end
`endif
    end

    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
            inc_q <= ACC_W'(DEF_INC);
            ce_q  <= 1'b0;
        end else begin
            acc_q <= acc_d;
            ce_q  <= ce_d;
            if (wr_inc_i) begin
                inc_q <= inc_i;
            end
        end
    end

    assign ce_o = ce_q;

endmodule

// File: rtl/clk_en_gen.sv
// Clock-enable generator: NUM_CH phase accumulators behind a settle/lock config controller.
// Optional CLKEN_PHASE_EN: a config write also loads the target channel's accumulator phase.
module clk_en_gen
    import clk_en_gen_pkg::*;
#(
    parameter int unsigned NUM_CH      = 5,
    parameter int unsigned ACC_W       = 32,
    parameter int unsigned LOCK_CYCLES = 1024,
    parameter int unsigned DEF_INC     = 0
) (
    input  logic              refclk,
    input  logic              rst_n,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [ACC_W-1:0]  cfg_inc,
    input  logic [ACC_W-1:0]  cfg_phase,
    output logic              cfg_err,
    output logic [NUM_CH-1:0] outce,
    output logic              locked
);

    localparam int unsigned CNT_W = $clog2(LOCK_CYCLES);
    localparam int unsigned CMP_W = CH_W + 1;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ready_q, ready_d;
    logic             locked_q, locked_d;
    logic             err_q, err_d;
    logic [CH_W-1:0]  ch_q, ch_d;
    logic [ACC_W-1:0] inc_q, inc_d;
    logic             hs_c, ch_ok_c, apply_c;

`ifdef CLKEN_PHASE_EN
    logic [ACC_W-1:0] phase_q, phase_d;
`else
    logic             unused_phase;
    assign unused_phase = ^cfg_phase;
`endif

    assign hs_c    = cfg_valid && ready_q;
    assign ch_ok_c = {1'b0, cfg_ch} < CMP_W'(NUM_CH);
    assign apply_c = (state_q == APPLY);

    // Controller next state; an invalid channel only raises cfg_err.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ch_d    = ch_q;
        inc_d   = inc_q;
        err_d   = hs_c && !ch_ok_c;
`ifdef CLKEN_PHASE_EN
        phase_d = phase_q;
`endif
        case (state_q)
            SETTLE, LOCKED: begin
                if (hs_c && ch_ok_c) begin
                    state_d = APPLY;
                    ch_d    = cfg_ch;
                    inc_d   = cfg_inc;
`ifdef CLKEN_PHASE_EN
                    phase_d = cfg_phase;
`endif
                end else if (state_q == SETTLE) begin
                    if (cnt_q == CNT_W'(LOCK_CYCLES - 1)) begin
                        state_d = LOCKED;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            APPLY: begin
                state_d = SETTLE;
                cnt_d   = '0;
            end
            default: begin
                state_d = SETTLE;
                cnt_d   = '0;
            end
        endcase
        ready_d  = (state_d != APPLY);
        locked_d = (state_d == LOCKED);
    end

    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= SETTLE;
            cnt_q    <= '0;
            ready_q  <= 1'b0;
            locked_q <= 1'b0;
            err_q    <= 1'b0;
            ch_q     <= '0;
            inc_q    <= '0;
`ifdef CLKEN_PHASE_EN
            phase_q  <= '0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            ready_q  <= ready_d;
            locked_q <= locked_d;
            err_q    <= err_d;
            ch_q     <= ch_d;
            inc_q    <= inc_d;
`ifdef CLKEN_PHASE_EN
            phase_q  <= phase_d;
`endif
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        clk_en_chan #(
            .ACC_W   (ACC_W),
            .DEF_INC (DEF_INC)
        ) u_chan (
            .refclk   (refclk),
            .rst_n    (rst_n),
            .wr_inc_i (apply_c && (ch_q == CH_W'(i))),
            .inc_i    (inc_q),
`ifdef CLKEN_PHASE_EN
            .ld_acc_i (apply_c && (ch_q == CH_W'(i))),
            .phase_i  (phase_q),
`endif
            .ce_o     (outce[i])
        );
    end

    assign cfg_ready = ready_q;
    assign cfg_err   = err_q;
    assign locked    = locked_q;

endmodule

// File: tb/tb_clk_en_gen.sv
// Self-checking bench for clk_en_gen (ACC_W=8, NUM_CH=5, LOCK_CYCLES=16, DEF_INC=5).
// Build with CLKEN_PHASE_EN defined to also cover the phase-load feature.
module tb_clk_en_gen;

    localparam int NUM_CH      = 5;
    localparam int ACC_W       = 8;
    localparam int LOCK_CYCLES = 16;
    localparam int DEF_INC     = 5;
    localparam int MODULUS     = 256;
`ifdef CLKEN_PHASE_EN
    localparam bit PH = 1'b1;
`else
    localparam bit PH = 1'b0;
`endif

    logic              refclk = 1'b0;
    logic              rst_n  = 1'b0;
    logic              cfg_valid = 1'b0;
    logic              cfg_ready;
    logic [3:0]        cfg_ch = '0;
    logic [ACC_W-1:0]  cfg_inc = '0;
    logic [ACC_W-1:0]  cfg_phase = '0;
    logic              cfg_err;
    logic [NUM_CH-1:0] outce;
    logic              locked;

    always #5 refclk = ~refclk;

    clk_en_gen #(
        .NUM_CH      (NUM_CH),
        .ACC_W       (ACC_W),
        .LOCK_CYCLES (LOCK_CYCLES),
        .DEF_INC     (DEF_INC)
    ) dut (
        .refclk    (refclk),
        .rst_n     (rst_n),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_ch    (cfg_ch),
        .cfg_inc   (cfg_inc),
        .cfg_phase (cfg_phase),
        .cfg_err   (cfg_err),
        .outce     (outce),
        .locked    (locked)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model: accumulators as plain integers, lock as cycles remaining.
    int                m_acc [NUM_CH];
    int                m_inc [NUM_CH];
    logic [NUM_CH-1:0] m_out;
    int                settle_left;
    logic              m_ready, m_err, m_locked;
    bit                pend;
    int                p_ch, p_inc, p_phase;

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < NUM_CH; i++) begin
            m_acc[i] = 0;
            m_inc[i] = DEF_INC;
        end
        m_out       = '0;
        settle_left = LOCK_CYCLES;
        m_ready     = 1'b0;
        m_err       = 1'b0;
        m_locked    = 1'b0;
        pend        = 1'b0;
    endfunction

    function automatic void model_edge(bit v, int ch, int inc, int ph);
        bit hs;
        int s;
        hs = v && m_ready;
        for (int i = 0; i < NUM_CH; i++) begin
            if (pend && PH && i == p_ch) begin
                m_acc[i] = p_phase;
                m_out[i] = 1'b0;
            end else begin
                s        = m_acc[i] + m_inc[i];
                m_out[i] = (s >= MODULUS);
                m_acc[i] = s % MODULUS;
            end
        end
        if (pend) begin
            m_inc[p_ch] = p_inc;
            pend        = 1'b0;
        end
        m_err = hs && (ch >= NUM_CH);
        if (hs && ch < NUM_CH) begin
            pend        = 1'b1;
            p_ch        = ch;
            p_inc       = inc;
            p_phase     = ph;
            settle_left = LOCK_CYCLES + 1;
        end else if (settle_left > 0) begin
            settle_left--;
        end
        m_ready  = !pend;
        m_locked = (settle_left == 0);
    endfunction

    task automatic check_outputs();
        check("outce", 32'(outce), 32'(m_out));
        check("cfg_ready", 32'(cfg_ready), 32'(m_ready));
        check("locked", 32'(locked), 32'(m_locked));
        check("cfg_err", 32'(cfg_err), 32'(m_err));
    endtask

    task automatic cyc();
        bit v;
        int ch, inc, ph;
        v   = cfg_valid;
        ch  = int'(cfg_ch);
        inc = int'(cfg_inc);
        ph  = int'(cfg_phase);
        @(posedge refclk);
        model_edge(v, ch, inc, ph);
        #1;
        check_outputs();
    endtask

    // Returns just after the handshake edge with cfg_valid dropped.
    task automatic write(int ch, int inc, int ph);
        int n;
        n         = 0;
        cfg_valid = 1'b1;
        cfg_ch    = 4'(ch);
        cfg_inc   = 8'(inc);
        cfg_phase = 8'(ph);
        while (!m_ready && n < 8) begin
            cyc();
            n++;
        end
        cyc();
        cfg_valid = 1'b0;
    endtask

    initial begin
        int n, cnt, last, bad;
        logic [39:0] hist0, hist1;

        // Reset holds every output low.
        model_reset();
        repeat (3) @(posedge refclk);
        #1;
        check("rst_outce", 32'(outce), 0);
        check("rst_ready", 32'(cfg_ready), 0);
        check("rst_locked", 32'(locked), 0);
        check("rst_err", 32'(cfg_err), 0);

        // Release: ready on the first edge, locked on the 16th.
        @(negedge refclk);
        rst_n = 1'b1;
        cyc();
        check("ready_first_edge", 32'(cfg_ready), 1);
        repeat (14) cyc();
        check("unlocked_at_15", 32'(locked), 0);
        cyc();
        check("locked_at_16", 32'(locked), 1);

        // ch0 inc=64: relock 17 cycles after the handshake, then 100 pulses per 400 cycles.
        write(0, 64, 0);
        check("locked_drop", 32'(locked), 0);
        n = 0;
        while (n < 30) begin
            cyc();
            n++;
            if (locked === 1'b1) break;
        end
        check("relock_cycles", 32'(n), 17);
        cnt = 0;
        for (int t = 0; t < 400; t++) begin
            cyc();
            if (outce[0] === 1'b1) cnt++;
        end
        check("ch0_pulses_400", 32'(cnt), 100);

        // ch1 inc=3: 3 pulses per 256 cycles, spacing 85 or 86.
        write(1, 3, 0);
        cyc();
        cnt  = 0;
        last = -1;
        bad  = 0;
        for (int t = 0; t < 600; t++) begin
            cyc();
            if (outce[1] === 1'b1) begin
                if (t < 256) cnt++;
                if (last >= 0 && (t - last) != 85 && (t - last) != 86) bad++;
                last = t;
            end
        end
        check("ch1_pulses_256", 32'(cnt), 3);
        check("ch1_spacing", 32'(bad), 0);

        // Invalid channel: one-cycle error, lock and patterns untouched.
        write(7, 8'h11, 0);
        check("err_pulse", 32'(cfg_err), 1);
        check("err_locked_kept", 32'(locked), 1);
        cyc();
        check("err_clear", 32'(cfg_err), 0);
        check("err_locked_still", 32'(locked), 1);
        repeat (8) cyc();

        // Phase alignment: loads four cycles apart so ch0 has come back to phase 0.
        write(0, 64, 0);
        repeat (3) cyc();
        write(1, 64, 128);
        for (int t = 0; t < 40; t++) begin
            cyc();
            hist0[t] = outce[0];
            hist1[t] = outce[1];
        end
`ifdef CLKEN_PHASE_EN
        bad = 0;
        for (int t = 2; t < 40; t++) begin
            if (hist1[t] !== hist0[t-2]) bad++;
        end
        check("phase_offset2", 32'(bad), 0);
        check("phase_ch0_count", 32'($countones(hist0)), 10);
`endif

        // Randomized config traffic, including invalid channels and idle input noise.
        for (int t = 0; t < 400; t++) begin
            cfg_valid = ($urandom_range(0, 3) == 0);
            cfg_ch    = 4'($urandom_range(0, 7));
            cfg_inc   = 8'($urandom);
            cfg_phase = 8'($urandom);
            cyc();
        end
        cfg_valid = 1'b0;
        repeat (4) cyc();

        // Reset during APPLY: outputs drop at once, increments return to DEF_INC.
        write(2, 100, 0);
        check("apply_ready_low", 32'(cfg_ready), 0);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_outce", 32'(outce), 0);
        check("midrst_ready", 32'(cfg_ready), 0);
        check("midrst_locked", 32'(locked), 0);
        check("midrst_err", 32'(cfg_err), 0);
        model_reset();
        @(negedge refclk);
        rst_n = 1'b1;
        cnt = 0;
        for (int t = 0; t < 120; t++) begin
            cyc();
            if (outce[2] === 1'b1) cnt++;
        end
        check("post_rst_ch2_pulses", 32'(cnt), 2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
